// File: rtl/mem_pkg.sv
// Shared types for the memory access sequencer: FSM state encoding,
// default geometry and the parity helper used for the array word.
package mem_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        CAPTURE,
        RESP
    } state_t;

    // XOR reduction; callers zero-extend narrower words, which
    // leaves the result unchanged.
    function automatic logic parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Request sequencer in front of the word-line decoder and memory array.
// Takes one read/write request at a time (req_valid/req_ready), drives a
// registered row address to the decoder, strobes the array with one setup
// cycle plus ACCESS_CYCLES strobe cycles (plus a capture cycle for reads),
// and returns one response per request (resp_valid/resp_ready).
// Ports:
//   clk, rst                         clock, async active-high reset
//   req_valid/ready/we/addr/wdata    request channel
//   dec_addr                         registered address to the decoder
//   arr_we, arr_re                   array write / read strobes
//   arr_wdata, arr_rdata             array data (one extra parity bit
//                                    when MEM_ACCESS_PARITY_EN is defined)
//   resp_valid/ready/we/rdata        response channel
//   resp_perr                        read parity error, only with
//                                    MEM_ACCESS_PARITY_EN defined
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int ADDR_W        = DEFAULT_ADDR_W,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] dec_addr,
    output logic              arr_we,
    output logic              arr_re,
`ifdef MEM_ACCESS_PARITY_EN
    output logic [DATA_W:0]   arr_wdata,
    input  logic [DATA_W:0]   arr_rdata,
    output logic              resp_perr,
`else
    output logic [DATA_W-1:0] arr_wdata,
    input  logic [DATA_W-1:0] arr_rdata,
`endif
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_we,
    output logic [DATA_W-1:0] resp_rdata
);

    generate
        if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_cycles
            $error("mem_access_ctrl: ACCESS_CYCLES must be 1..15");
        end
    endgenerate

    state_t     state;
    state_t     nstate;
    logic [3:0] cnt;
    logic       we_q;
    logic       rdy_q;
    logic       accept;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next-state logic.
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (accept)       nstate = SETUP;
            SETUP:                     nstate = ACCESS;
            ACCESS:  if (cnt == 4'd0)  nstate = we_q ? RESP : CAPTURE;
            CAPTURE:                   nstate = RESP;
            RESP:    if (resp_ready)   nstate = IDLE;
            default:                   nstate = IDLE;
        endcase
    end

    // Outputs decoded from state. rdy_q holds req_ready low during
    // reset and for the release cycle.
    always_comb begin
        req_ready  = (state == IDLE) && rdy_q;
        arr_we     = (state == ACCESS) && we_q;
        arr_re     = ((state == ACCESS) && !we_q) || (state == CAPTURE);
        resp_valid = (state == RESP);
    end

    assign accept  = req_valid && req_ready;
    assign resp_we = we_q;

    // Datapath registers and the strobe down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q      <= 1'b0;
            dec_addr   <= '0;
            we_q       <= 1'b0;
            arr_wdata  <= '0;
            resp_rdata <= '0;
            cnt        <= 4'd0;
`ifdef MEM_ACCESS_PARITY_EN
            resp_perr  <= 1'b0;
`endif
        end else begin
            rdy_q <= 1'b1;
            if (accept) begin
                dec_addr   <= req_addr;
                we_q       <= req_we;
`ifdef MEM_ACCESS_PARITY_EN
                arr_wdata  <= {parity(64'(req_wdata)), req_wdata};
                resp_perr  <= 1'b0;
`else
                arr_wdata  <= req_wdata;
`endif
                resp_rdata <= '0;
            end
            if (state == SETUP)
                cnt <= 4'(ACCESS_CYCLES - 1);
            else if (state == ACCESS && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == CAPTURE) begin
                resp_rdata <= arr_rdata[DATA_W-1:0];
`ifdef MEM_ACCESS_PARITY_EN
                resp_perr  <= ^arr_rdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus random
// read/write traffic checked against a simple memory reference.
module tb_mem_access_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int AC = 2;
`ifdef MEM_ACCESS_PARITY_EN
    localparam int WW = DW + 1;
`else
    localparam int WW = DW;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [AW-1:0] dec_addr;
    logic          arr_we;
    logic          arr_re;
    logic [WW-1:0] arr_wdata;
    logic [WW-1:0] arr_rdata;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          resp_we;
    logic [DW-1:0] resp_rdata;
`ifdef MEM_ACCESS_PARITY_EN
    logic          resp_perr;
`endif

    mem_access_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .ACCESS_CYCLES(AC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .dec_addr(dec_addr), .arr_we(arr_we), .arr_re(arr_re),
        .arr_wdata(arr_wdata), .arr_rdata(arr_rdata),
`ifdef MEM_ACCESS_PARITY_EN
        .resp_perr(resp_perr),
`endif
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_we(resp_we), .resp_rdata(resp_rdata)
    );

    always #5 clk = ~clk;

    // Array behaviour: synchronous write, combinational read with an
    // optional bit-flip mask to emulate corrupted words.
    logic [WW-1:0] amem [8];
    logic [WW-1:0] inj = '0;
    always @(posedge clk) if (arr_we) amem[dec_addr] <= arr_wdata;
    assign arr_rdata = amem[dec_addr] ^ inj;

    logic [DW-1:0] ref_mem [8];
    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] word(input logic [DW-1:0] d);
        logic [WW-1:0] w;
        w = WW'(d);
`ifdef MEM_ACCESS_PARITY_EN
        w[DW] = ^d;
`endif
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input int bp,
                       input logic [WW-1:0] mask);
        int cyc, nstb, nbad;
        logic [DW-1:0] exp_rd;
        logic exp_pe;
        req_we = we; req_addr = addr; req_wdata = data;
        req_valid = 1'b1; inj = mask;
        cyc = 0;
        while (!req_ready && cyc < 20) begin tick(); cyc++; end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        exp_rd = we ? '0 : ref_mem[addr] ^ mask[DW-1:0];
        exp_pe = we ? 1'b0 : ^(word(ref_mem[addr]) ^ mask);
        if (we) ref_mem[addr] = data;
        tick();
        // Requester garbage while busy must be ignored.
        req_valid = 1'($urandom); req_we = 1'($urandom);
        req_addr = AW'($urandom); req_wdata = DW'($urandom);
        chk("req_ready_drop", 32'(req_ready), 32'd0);
        chk("dec_addr_c1", 32'(dec_addr), 32'(addr));
        cyc = 1; nstb = 0; nbad = 0;
        while (!resp_valid && cyc < 40) begin
            if (arr_we && arr_re) nbad++;
            if (we ? arr_re : arr_we) nbad++;
            if (arr_we || arr_re) begin
                nstb++;
                if (dec_addr !== addr || arr_wdata !== word(data)) nbad++;
            end
            resp_ready = 1'($urandom);
            tick(); cyc++;
        end
        resp_ready = 1'b0;
        chk("resp_latency", 32'(cyc), 32'(we ? 2 + AC : 3 + AC));
        chk("strobe_cycles", 32'(nstb), 32'(we ? AC : AC + 1));
        chk("strobe_errors", 32'(nbad), 32'd0);
        chk("strobe_resp", 32'(arr_we | arr_re), 32'd0);
        chk("resp_we", 32'(resp_we), 32'(we));
        chk("resp_rdata", 32'(resp_rdata), 32'(exp_rd));
`ifdef MEM_ACCESS_PARITY_EN
        chk("resp_perr", 32'(resp_perr), 32'(exp_pe));
`endif
        nbad = 0;
        for (int i = 0; i < bp; i++) begin
            tick();
            if (!resp_valid || resp_rdata !== exp_rd || req_ready
                || dec_addr !== addr || arr_we || arr_re) nbad++;
        end
        if (bp > 0) chk("backpressure", 32'(nbad), 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req_valid = 1'b0;
        chk("post_hs_valid", 32'(resp_valid), 32'd0);
        chk("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int cyc, nbad;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_dec_addr", 32'(dec_addr), 32'd0);
        chk("rst_arr_wdata", 32'(arr_wdata), 32'd0);
        chk("rst_resp", 32'({resp_we, resp_rdata}), 32'd0);
        chk("rst_strobes", 32'({arr_we, arr_re}), 32'd0);
        tick(); tick();
        rst = 1'b0;
        chk("rel_req_ready", 32'(req_ready), 32'd0);
        tick();
        chk("ready_after_rel", 32'(req_ready), 32'd1);

        txn(1'b1, 3'd5, 8'hA5, 0, '0);
        txn(1'b1, 3'd3, 8'h3C, 0, '0);
        txn(1'b0, 3'd3, 8'h00, 0, '0);
        txn(1'b0, 3'd5, 8'h11, 6, '0);

        // Reset in the middle of a write access.
        req_we = 1'b1; req_addr = 3'd6; req_wdata = 8'h5A;
        req_valid = 1'b1;
        cyc = 0;
        while (!req_ready && cyc < 20) begin tick(); cyc++; end
        tick();
        req_valid = 1'b0;
        cyc = 0;
        while (!arr_we && cyc < 10) begin tick(); cyc++; end
        chk("rst_mid_reach", 32'(arr_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", 32'(arr_we), 32'd0);
        chk("rst_mid_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid_addr", 32'(dec_addr), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        resp_ready = 1'b1;
        nbad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid || arr_we || arr_re) nbad++;
        end
        resp_ready = 1'b0;
        chk("rst_mid_noresp", 32'(nbad), 32'd0);

        for (int a = 0; a < 8; a++) begin
            txn(1'b1, AW'(a), DW'(a * 8'h11), 0, '0);
            txn(1'b0, AW'(a), DW'($urandom), 0, '0);
        end

`ifdef MEM_ACCESS_PARITY_EN
        txn(1'b1, 3'd1, 8'h07, 0, '0);
        chk("par_word", 32'(amem[1]), 32'h107);
        txn(1'b0, 3'd1, 8'h00, 0, '0);
        txn(1'b0, 3'd1, 8'h00, 0, WW'(9'h100));
`endif

        for (int n = 0; n < 60; n++) begin
            logic [WW-1:0] m;
            m = '0;
`ifdef MEM_ACCESS_PARITY_EN
            if ($urandom_range(0, 3) == 0)
                m = WW'(1) << $urandom_range(0, DW);
`endif
            txn(1'($urandom), AW'($urandom), DW'($urandom),
                int'($urandom_range(0, 3)), m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Request sequencer directly upstream of the 3-to-8 word-line decoder and the memory array.
- Accepts one read or write request at a time through a valid/ready handshake.
- Drives a registered address onto the decoder inputs, then drives the array enable strobes with fixed setup and access timing.
- Captures read data and returns a single response per request through a valid/ready handshake.

Parameters:
- DATA_W, 8, width of the array data word.
- ADDR_W, 3, address width (matches decoder input; 2**ADDR_W rows).
- ACCESS_CYCLES, 2, cycles the array strobe is held asserted; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  row address.
- req_wdata  in  DATA_W  write data.
- dec_addr  out  ADDR_W  registered address to the decoder.
- arr_we  out  1  array write strobe.
- arr_re  out  1  array read strobe.
- arr_wdata  out  DATA_W(+1 with parity)  data to the array.
- arr_rdata  in  DATA_W(+1 with parity)  data from the array.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_we  out  1  echo of the request type.
- resp_rdata  out  DATA_W  read data; 0 for writes.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - State = IDLE.
  - dec_addr, arr_wdata, resp_rdata = 0.
  - arr_we, arr_re, resp_valid, resp_we = 0.
  - req_ready = 1 one cycle after rst deasserts.
  - A request in flight is dropped; no response is generated.
- FSM states: IDLE, SETUP, ACCESS, CAPTURE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch req_addr into dec_addr, req_we, and req_wdata into arr_wdata; go to SETUP.
- SETUP:
  - Exactly 1 cycle.
  - Address stable at the decoder; strobes low.
  - Go to ACCESS.
- ACCESS:
  - arr_we (write) or arr_re (read) held high for exactly ACCESS_CYCLES cycles, counted by a 4-bit down-counter.
  - dec_addr and arr_wdata are unchanged throughout.
  - At terminal count: read goes to CAPTURE; write goes to RESP.
- CAPTURE (read only):
  - arr_re stays high for this cycle.
  - resp_rdata samples arr_rdata at the end of the cycle.
  - Go to RESP.
- RESP:
  - resp_valid = 1; resp_we, resp_rdata, and dec_addr are stable.
  - Held until resp_ready; the handshake cycle returns the FSM to IDLE.
- req_ready is 1 only in IDLE.
- No back-to-back overlap: the next request is accepted no earlier than the cycle after the response handshake.
- resp_ready held high:
  - Write response appears at cycle 2+ACCESS_CYCLES after acceptance.
  - Read response appears at cycle 3+ACCESS_CYCLES after acceptance.
- Strobes are never both high.
- Strobes are low in IDLE, SETUP, and RESP.
- dec_addr changes only in the IDLE acceptance cycle.
- resp_ready asserted outside RESP is ignored.
- req_valid asserted outside IDLE is ignored; the requester must hold it.
- Out-of-range ACCESS_CYCLES (0 or >15) raises an elaboration-time error.

Optional Feature:
- Macro MEM_ACCESS_PARITY_EN.
- When defined:
  - Array word is DATA_W+1 bits; arr_wdata[DATA_W] = even parity (XOR) of req_wdata.
  - On CAPTURE, the XOR of all DATA_W+1 bits of arr_rdata is registered to extra output resp_perr (1 = error); resp_perr = 0 for writes and on reset.
  - resp_rdata still carries the data bits unchanged.
- When undefined:
  - Array word is DATA_W bits.
  - The resp_perr port does not exist.

Decomposition:
- Shared package mem_pkg holds:
  - state enum typedef (IDLE, SETUP, ACCESS, CAPTURE, RESP);
  - localparam DEFAULT_DATA_W = 8, DEFAULT_ADDR_W = 3;
  - parity function.
- No sub-module is required.
- The existing decoder is instantiated beside this block at top level, not inside it.

Test Plan:
- Write addr=5, data=0xA5, ACCESS_CYCLES=2:
  - req_ready drops the cycle after acceptance;
  - dec_addr=5 from cycle 1;
  - arr_we high cycles 2-3;
  - resp_valid at cycle 4 with resp_we=1, resp_rdata=0.
- Read addr=3, arr_rdata model returns 0x3C:
  - arr_re high cycles 2-4;
  - resp_valid at cycle 5 with resp_rdata=0x3C, resp_we=0.
- Backpressure: hold resp_ready=0 for 6 cycles:
  - resp_valid and resp_rdata stay stable;
  - req_ready stays 0;
  - second req_valid is not accepted until the cycle after the handshake.
- Sweep addr 0..7, write then read each with data=addr*0x11:
  - every readback matches;
  - dec_addr equals addr during every strobe.
- Assert rst during ACCESS of a write:
  - arr_we, resp_valid, dec_addr go to 0 immediately;
  - no response is produced;
  - req_ready = 1 after release.
- With MEM_ACCESS_PARITY_EN:
  - write 0x07 sets arr_wdata[8]=1;
  - read returning 0x107 gives resp_perr=0;
  - read returning 0x007 gives resp_perr=1.
